// File: rtl/conv_layer_seq_if.sv
// Job/result handshake bundle for the sequential conv layer.
// master drives jobs and consumes results; slave is the layer itself.
interface conv_layer_seq_if #(
    parameter int bitwidth = 16,
    parameter int CH       = 2,
    parameter int K        = 5,
    parameter int NK       = 10
);
    logic in_valid;
    logic in_ready;
    logic signed [CH-1:0][K-1:0][K-1:0][bitwidth-1:0] featuremap_in;
    logic signed [NK-1:0][CH-1:0][K-1:0][K-1:0][bitwidth-1:0] kernel;
    logic out_valid;
    logic out_ready;
    logic signed [NK-1:0][bitwidth-1:0] featuremap_out;
    logic busy;

    modport master (
        output in_valid, featuremap_in, kernel, out_ready,
        input  in_ready, out_valid, featuremap_out, busy
    );

    modport slave (
        input  in_valid, featuremap_in, kernel, out_ready,
        output in_ready, out_valid, featuremap_out, busy
    );
endinterface

// File: rtl/conv_layer_seq.sv
// Time-multiplexed conv layer: CH x K x K window against NK kernels,
// one MAC per clock, with scaling, saturation and optional ReLU.
module conv_layer_seq #(
    parameter int bitwidth  = 16,
    parameter int CH        = 2,
    parameter int K         = 5,
    parameter int NK        = 10,
    parameter int FRAC_BITS = 0,
    parameter bit RELU_EN   = 1'b0
) (
    input logic clk,
    input logic rst,
    conv_layer_seq_if.slave bus
);
    localparam int TAPS = CH * K * K;
    localparam int AW   = 2 * bitwidth + $clog2(TAPS);
    localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int KW   = (NK > 1) ? $clog2(NK) : 1;
    localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (bitwidth - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic signed [bitwidth-1:0] fm_q [TAPS];
    logic signed [bitwidth-1:0] kern_q [NK][TAPS];
    logic signed [AW-1:0] acc_q;
    logic [TW-1:0] t_q;
    logic [KW-1:0] k_q;
    logic [NK-1:0][bitwidth-1:0] out_q;

    logic signed [2*bitwidth-1:0] prod;
    logic signed [AW-1:0] prod_x;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic signed [bitwidth-1:0] res;
    logic last_tap;
    logic last_k;
    logic accept;

    assign last_tap = (t_q == TW'(TAPS - 1));
    assign last_k   = (k_q == KW'(NK - 1));
    assign accept   = (state_q == IDLE) && bus.in_valid;

    always_comb begin
        prod    = fm_q[t_q] * kern_q[k_q][t_q];
        prod_x  = prod;
        sum     = acc_q + prod_x;
        shifted = sum >>> FRAC_BITS;
        if (shifted > MAXV) begin
            res = MAXV[bitwidth-1:0];
        end else if (shifted < MINV) begin
            res = MINV[bitwidth-1:0];
        end else begin
            res = shifted[bitwidth-1:0];
        end
        if (RELU_EN && res[bitwidth-1]) begin
            res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_tap && last_k) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand copies are only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int c = 0; c < CH; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int x = 0; x < K; x++) begin
                        fm_q[(c*K + r)*K + x] <= bus.featuremap_in[c][r][x];
                        for (int n = 0; n < NK; n++) begin
                            kern_q[n][(c*K + r)*K + x] <= bus.kernel[n][c][r][x];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            t_q   <= '0;
            k_q   <= '0;
            out_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
            t_q   <= '0;
            k_q   <= '0;
        end else if (state_q == RUN) begin
            if (last_tap) begin
                out_q[k_q] <= res;
                acc_q      <= '0;
                t_q        <= '0;
                k_q        <= last_k ? '0 : k_q + KW'(1);
            end else begin
                acc_q <= sum;
                t_q   <= t_q + TW'(1);
            end
        end
    end

    assign bus.featuremap_out = out_q;
endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: default, ReLU and
// fractional-scaling instances driven from one sequence.
module tb_conv_layer_seq;
    localparam int CH = 2;
    localparam int K  = 5;
    localparam int NK = 10;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_layer_seq_if if_d ();
    conv_layer_seq_if if_r ();
    conv_layer_seq_if if_f ();

    conv_layer_seq u_d (.clk(clk), .rst(rst), .bus(if_d.slave));
    conv_layer_seq #(.RELU_EN(1'b1)) u_r (.clk(clk), .rst(rst), .bus(if_r.slave));
    conv_layer_seq #(.FRAC_BITS(8)) u_f (.clk(clk), .rst(rst), .bus(if_f.slave));

    task automatic drive(input int sel, input int fv, input int kv,
                         input int kstep, input logic v);
        logic [CH-1:0][K-1:0][K-1:0][15:0] fp;
        logic [NK-1:0][CH-1:0][K-1:0][K-1:0][15:0] kp;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < K; r++)
                for (int x = 0; x < K; x++) begin
                    fp[c][r][x] = 16'(fv);
                    for (int n = 0; n < NK; n++) kp[n][c][r][x] = 16'(kv + n * kstep);
                end
        case (sel)
            0: begin if_d.featuremap_in = fp; if_d.kernel = kp; if_d.in_valid = v; end
            1: begin if_r.featuremap_in = fp; if_r.kernel = kp; if_r.in_valid = v; end
            default: begin if_f.featuremap_in = fp; if_f.kernel = kp; if_f.in_valid = v; end
        endcase
    endtask

    task automatic set_iv(input int sel, input logic v);
        case (sel)
            0: if_d.in_valid = v;
            1: if_r.in_valid = v;
            default: if_f.in_valid = v;
        endcase
    endtask

    task automatic set_or(input int sel, input logic v);
        case (sel)
            0: if_d.out_ready = v;
            1: if_r.out_ready = v;
            default: if_f.out_ready = v;
        endcase
    endtask

    function automatic logic get_ov(input int sel);
        case (sel)
            0: return if_d.out_valid;
            1: return if_r.out_valid;
            default: return if_f.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int sel);
        case (sel)
            0: return if_d.in_ready;
            1: return if_r.in_ready;
            default: return if_f.in_ready;
        endcase
    endfunction

    function automatic logic [15:0] get_out(input int sel, input int n);
        case (sel)
            0: return if_d.featuremap_out[n];
            1: return if_r.featuremap_out[n];
            default: return if_f.featuremap_out[n];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one job, then count edges until out_valid (bounded).
    task automatic run_job(input int sel, input int fv, input int kv,
                           input int kstep, output int edges);
        drive(sel, fv, kv, kstep, 1'b1);
        tick();
        set_iv(sel, 1'b0);
        edges = 0;
        while (!get_ov(sel) && edges < 600) begin
            tick();
            edges++;
        end
    endtask

    task automatic release_out(input int sel);
        set_or(sel, 1'b1);
        tick();
        set_or(sel, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if (if_d.in_ready !== 1'b1 || if_d.out_valid !== 1'b0 || if_d.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ir=%b ov=%b busy=%b exp 1 0 0",
                     if_d.in_ready, if_d.out_valid, if_d.busy);
        end
        checks++;
        if (if_d.featuremap_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", if_d.featuremap_out);
        end
        checks++;
        if (if_r.in_ready !== 1'b1 || if_f.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_other_ir got %b %b exp 1 1", if_r.in_ready, if_f.in_ready);
        end
    endtask

    task automatic test_ones();
        int e;
        run_job(0, 1, 1, 0, e);
        checks++;
        if (e !== 500) begin
            errors++;
            $display("FAIL ones_latency got %0d exp 500", e);
        end
        checks++;
        if (if_d.busy !== 1'b0 || if_d.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ones_done_flags got busy=%b ir=%b exp 0 0", if_d.busy, if_d.in_ready);
        end
        for (int n = 0; n < NK; n++) begin
            checks++;
            if (get_out(0, n) !== 16'd50) begin
                errors++;
                $display("FAIL ones_out k=%0d got %0d exp 50", n, $signed(get_out(0, n)));
            end
        end
        release_out(0);
        checks++;
        if (if_d.in_ready !== 1'b1 || if_d.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ones_release got ir=%b ov=%b exp 1 0", if_d.in_ready, if_d.out_valid);
        end
    endtask

    task automatic test_kstep();
        int e;
        run_job(0, 1, 0, 1, e);
        checks++;
        if (e !== 500) begin
            errors++;
            $display("FAIL kstep_latency got %0d exp 500", e);
        end
        for (int n = 0; n < NK; n++) begin
            checks++;
            if (get_out(0, n) !== 16'(50 * n)) begin
                errors++;
                $display("FAIL kstep_out k=%0d got %0d exp %0d", n, $signed(get_out(0, n)), 50 * n);
            end
        end
        release_out(0);
    endtask

    task automatic test_saturate();
        int e;
        int ok;
        run_job(0, 100, 100, 0, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(0, n) !== 16'h7fff) ok = 0;
        checks++;
        if (ok == 0 || e !== 500) begin
            errors++;
            $display("FAIL sat_pos got %0d lat %0d exp 32767 lat 500", $signed(get_out(0, 0)), e);
        end
        release_out(0);
        run_job(0, 100, -100, 0, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(0, n) !== 16'h8000) ok = 0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL sat_neg got %0d exp -32768", $signed(get_out(0, 0)));
        end
        release_out(0);
        run_job(1, 100, -100, 0, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(1, n) !== 16'h0000) ok = 0;
        checks++;
        if (ok == 0 || e !== 500) begin
            errors++;
            $display("FAIL relu_neg got %0d lat %0d exp 0 lat 500", $signed(get_out(1, 0)), e);
        end
        release_out(1);
        run_job(1, 1, 0, 1, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(1, n) !== 16'(50 * n)) ok = 0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL relu_pos got k9=%0d exp 450", $signed(get_out(1, 9)));
        end
        release_out(1);
    endtask

    task automatic test_frac();
        int e;
        int ok;
        run_job(2, 256, 128, 0, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(2, n) !== 16'd6400) ok = 0;
        checks++;
        if (ok == 0 || e !== 500) begin
            errors++;
            $display("FAIL frac_pos got %0d lat %0d exp 6400 lat 500", $signed(get_out(2, 0)), e);
        end
        release_out(2);
        run_job(2, 1, -1, 0, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(2, n) !== 16'hffff) ok = 0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL frac_floor got %0d exp -1", $signed(get_out(2, 0)));
        end
        release_out(2);
        run_job(2, 256, -1, 0, e);
        ok = 1;
        for (int n = 0; n < NK; n++) if (get_out(2, n) !== 16'(-50)) ok = 0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL frac_neg got %0d exp -50", $signed(get_out(2, 0)));
        end
        release_out(2);
    endtask

    task automatic test_hold();
        int e;
        int ok;
        drive(0, 1, 1, 0, 1'b1);
        tick();
        set_iv(0, 1'b0);
        repeat (100) tick();
        drive(0, 3, 3, 0, 1'b1);
        tick();
        set_iv(0, 1'b0);
        e = 101;
        while (!if_d.out_valid && e < 600) begin
            tick();
            e++;
        end
        checks++;
        if (e !== 500) begin
            errors++;
            $display("FAIL hold_latency got %0d exp 500", e);
        end
        drive(0, 2, 2, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            ok = 1;
            for (int n = 0; n < NK; n++) if (get_out(0, n) !== 16'd50) ok = 0;
            checks++;
            if (ok == 0 || if_d.out_valid !== 1'b1 || if_d.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got out0=%0d ov=%b ir=%b exp 50 1 0",
                         i, $signed(get_out(0, 0)), if_d.out_valid, if_d.in_ready);
            end
            tick();
        end
        set_iv(0, 1'b0);
        release_out(0);
        tick();
        checks++;
        if (if_d.in_ready !== 1'b1 || if_d.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_capture got ir=%b busy=%b exp 1 0", if_d.in_ready, if_d.busy);
        end
    endtask

    task automatic test_rst_midrun();
        int e;
        drive(0, 1, 1, 0, 1'b1);
        tick();
        set_iv(0, 1'b0);
        repeat (200) tick();
        checks++;
        if (if_d.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got %b exp 1", if_d.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (if_d.out_valid !== 1'b0 || if_d.in_ready !== 1'b1 || if_d.busy !== 1'b0 ||
            if_d.featuremap_out !== '0) begin
            errors++;
            $display("FAIL midrun_rst got ov=%b ir=%b busy=%b out=%h exp 0 1 0 0",
                     if_d.out_valid, if_d.in_ready, if_d.busy, if_d.featuremap_out);
        end
        rst = 1'b1;
        set_iv(0, 1'b1);
        tick();
        rst = 1'b0;
        set_iv(0, 1'b0);
        checks++;
        if (if_d.busy !== 1'b0 || if_d.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_priority got busy=%b ir=%b exp 0 1", if_d.busy, if_d.in_ready);
        end
        run_job(0, 1, 1, 0, e);
        checks++;
        if (e !== 500) begin
            errors++;
            $display("FAIL rerun_latency got %0d exp 500", e);
        end
        for (int n = 0; n < NK; n++) begin
            checks++;
            if (get_out(0, n) !== 16'd50) begin
                errors++;
                $display("FAIL rerun_out k=%0d got %0d exp 50", n, $signed(get_out(0, n)));
            end
        end
        release_out(0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        drive(1, 0, 0, 0, 1'b0);
        drive(2, 0, 0, 0, 1'b0);
        set_or(0, 1'b0);
        set_or(1, 1'b0);
        set_or(2, 1'b0);
        repeat (2) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_ones();
        test_kstep();
        test_saturate();
        test_frac();
        test_hold();
        test_rst_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
